panel_uart_rx_monitor: RTL



---
 rtl/ret_thinge_pkg.sv | 15 +
 rtl/uart_bit_timer.sv | 27 ++
 rtl/panel_uart_rx_monitor.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/ret_thinge_pkg.sv
// Shared types and constants for the panel UART receive monitors.
package ret_thinge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } uart_rx_state_t;

    localparam int UART_CLKS_PER_BIT_115200 = 217;
    localparam int UART_BREAK_BITS          = 10;

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter for UART bit timing; zero marks a sample point.
module uart_bit_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Parks at zero until the next reload so the sample point stays visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/panel_uart_rx_monitor.sv
// Passive 8N1 UART tap for one panel receive line with byte/error counters.
// Optional break detection is enabled by defining PANEL_UART_BREAK_DET_EN.
module panel_uart_rx_monitor
    import ret_thinge_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_115200,
    parameter int CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rx_i,
    output logic [7:0]       data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [31:0]      byte_cnt_o,
    output logic [CNT_W-1:0] frame_err_cnt_o,
    output logic [CNT_W-1:0] overrun_cnt_o,
    output logic             break_o
);

    localparam int              TW        = $clog2(CLKS_PER_BIT);
    localparam int              HALF      = CLKS_PER_BIT / 2;
    localparam logic [TW-1:0]   HALF_LOAD = TW'(HALF - 1);
    localparam logic [TW-1:0]   FULL_LOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic           rx_meta;
    logic           rx_s;
    uart_rx_state_t state;
    logic [7:0]     shift;
    logic [2:0]     bit_idx;
    logic           timer_load;
    logic [TW-1:0]  timer_val;
    logic           timer_zero;

    // Synchronizer flops reset to the idle level so reset never looks like a start bit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
        end
    end

    always_comb begin
        timer_load = 1'b0;
        timer_val  = FULL_LOAD;
        case (state)
            IDLE: begin
                timer_load = ~rx_s;
                timer_val  = HALF_LOAD;
            end
            START, DATA: timer_load = timer_zero;
            default: timer_load = 1'b0;
        endcase
    end

    uart_bit_timer #(.W(TW)) u_timer (
        .clk      (clk_i),
        .rst      (rst_i),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

    // A transfer and a new load in the same cycle leave valid_o set.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= IDLE;
            shift           <= '0;
            bit_idx         <= '0;
            data_o          <= '0;
            valid_o         <= 1'b0;
            byte_cnt_o      <= '0;
            frame_err_cnt_o <= '0;
            overrun_cnt_o   <= '0;
        end else begin
            if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                    end
                end
                START: begin
                    if (timer_zero) begin
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (timer_zero) begin
                        shift   <= {rx_s, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (timer_zero) begin
                        if (rx_s) begin
                            byte_cnt_o <= byte_cnt_o + 32'd1;
                            if (!valid_o || ready_i) begin
                                data_o  <= shift;
                                valid_o <= 1'b1;
                            end else if (overrun_cnt_o != CNT_MAX) begin
                                overrun_cnt_o <= overrun_cnt_o + CNT_ONE;
                            end
                            state <= IDLE;
                        end else begin
                            if (frame_err_cnt_o != CNT_MAX) begin
                                frame_err_cnt_o <= frame_err_cnt_o + CNT_ONE;
                            end
                            state <= WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PANEL_UART_BREAK_DET_EN
    localparam int            BREAK_LEN = UART_BREAK_BITS * CLKS_PER_BIT;
    localparam int            BW        = $clog2(BREAK_LEN + 1);
    localparam logic [BW-1:0] BRK_LAST  = BW'(BREAK_LEN - 1);
    localparam logic [BW-1:0] BRK_FULL  = BW'(BREAK_LEN);

    logic [BW-1:0] brk_cnt;

    // The failed stop sample counts as the first low cycle of a break.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            brk_cnt <= '0;
            break_o <= 1'b0;
        end else if (state == STOP && timer_zero && !rx_s) begin
            brk_cnt <= BW'(1);
        end else if (state == WAIT_HIGH) begin
            if (rx_s) begin
                brk_cnt <= '0;
                break_o <= 1'b0;
            end else begin
                if (brk_cnt != BRK_FULL) begin
                    brk_cnt <= brk_cnt + BW'(1);
                end
                if (brk_cnt >= BRK_LAST) begin
                    break_o <= 1'b1;
                end
            end
        end
    end
`else
    assign break_o = 1'b0;
`endif

endmodule
